gnn_mac_sched: RTL and testbench
================================

Name: gnn_mac_sched

Overview:
Sequencer for a time-multiplexed GNN datapath. A single shared MAC plus hidden and output buffers replace the fully parallel per-node multipliers. For each node, the block walks layer 0 (N_IN features x N_HID weights) and then layer 1 (N_HID hidden values x N_OUT weights). It drives operand selects, accumulator clear/enable and buffer write strobes, and reports per-output ready flags.

Parameters:
N_NODES, 4, number of graph nodes
N_IN, 4, input features per node (x0..x3)
N_HID, 4, hidden neurons (w*4..w*7)
N_OUT, 2, output neurons (w*8, w*9)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
in_ready  in  1  level; high = input features and weights are valid and held stable
busy  out  1  high while sequencing MAC/WB cycles
sel_layer  out  1  0 = input x hidden weights, 1 = hidden x output weights
sel_node  out  $clog2(N_NODES)  node currently being processed
sel_row  out  $clog2(max(N_IN,N_HID))  term index (feature or hidden index)
sel_col  out  $clog2(max(N_HID,N_OUT))  neuron index
mac_clr  out  1  accumulator loads product instead of adding (first term)
mac_en  out  1  accumulator update enable
hid_we  out  1  write accumulator into hidden buffer [sel_node][sel_col]
hid_relu  out  1  datapath clamps the hidden write to >=0 (see Optional Feature)
out_we  out  1  write accumulator into output register [sel_node][sel_col]
out_ready_vec  out  N_NODES*N_OUT  bit n*N_OUT+k is sticky ready for out k, node n
done  out  1  single-cycle pulse when all outputs are written

Behaviour:
- Reset (synchronous, active-high): state IDLE; all outputs are 0, including out_ready_vec and the sel_* outputs. rst overrides every other event, including mid-run.
- States: IDLE, MAC, WB, DONE.
- IDLE -> MAC when in_ready=1. The first MAC cycle is node0, layer0, col0, row0.
- MAC: mac_en=1. mac_clr=1 only when row=0. sel_row increments each cycle. After the last row (N_IN-1 in layer 0, N_HID-1 in layer 1), the next state is WB.
- WB: mac_en=0. hid_we=1 in layer 0; out_we=1 in layer 1. The selects hold the values of the last MAC cycle except sel_row. The datapath MAC has 1-cycle latency, so the accumulator holds the full sum during WB.
- After WB, advance col. On col wrap, advance layer. On layer wrap, advance node. After the last node's last WB, go to DONE.
- Cycles per neuron = terms + 1. Cycles per node = N_HID*(N_IN+1) + N_OUT*(N_HID+1) = 30 at defaults. Total 120 busy cycles.
- out_ready_vec bit sets on the clock edge that ends its out_we cycle, so it is visible together with the registered data.
- DONE: done=1 only in the first DONE cycle. busy=0. out_ready_vec is held. There is no re-run while in_ready stays high.
- DONE -> IDLE when in_ready=0. out_ready_vec clears on that transition.
- Abort: in_ready=0 during MAC/WB returns to IDLE on the next edge. All strobes are 0 from the next cycle. out_ready_vec is cleared. No partial writes occur after the abort edge.
- busy=1 exactly in MAC/WB.
- sel_* and strobes are registered state decodes; there are no combinational paths from in_ready to the strobes.

Optional Feature:
GNN_HIDDEN_RELU_EN:
- Defined: hid_relu = hid_we (ReLU applied to the hidden layer).
- Undefined: hid_relu is tied 0 and the hidden values are stored as the raw signed sums.
- Sequencing and cycle counts are identical either way.

Decomposition:
- Package gnn_sched_pkg: state enum (IDLE, MAC, WB, DONE), default sizes, index widths, the CYC_PER_NODE and TOTAL_CYC localparams, and the ready-bit index function n*N_OUT+k.
- Sub-module gnn_idx_counter: nested row/col/layer/node counter with per-layer term and column limits, wrap flags, and sync clear.
- gnn_mac_sched keeps the FSM, the strobe decode and out_ready_vec.

Test Plan:
- Reset: assert rst for 2 cycles with in_ready=1 -> all outputs 0. First MAC cycle is the cycle after rst falls; sel_*=0 and mac_clr=1.
- Full run, defaults: in_ready high until done -> cycle 1 starts MAC (counting from the start edge).
  - First hid_we at cycle 5.
  - First out_we at cycle 25 (node0, col0); bit0 of out_ready_vec visible at cycle 26.
  - Last out_we at cycle 120.
  - done at cycle 121.
  - busy high for exactly 120 cycles.
- Strobe counts per run: 16 hid_we and 8 out_we. mac_clr count = 24. mac_en count = 96. No two strobes in the same cycle.
- Abort: drop in_ready at cycle 40 -> next cycle IDLE, busy=0, out_ready_vec=0. No hid_we/out_we after that edge. Re-raise in_ready -> restart at node0.
- Hold in DONE: keep in_ready=1 for 20 cycles after done -> out_ready_vec=8'hFF held and no further strobes. Drop in_ready -> vec clears.
- Macro: build with and without GNN_HIDDEN_RELU_EN -> hid_relu equals hid_we versus constant 0. All other traces are identical.

Source files
------------

// File: rtl/gnn_sched_pkg.sv
// Shared types, default sizes and index helpers for the GNN MAC sequencer.
package gnn_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_WB   = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam int N_NODES_DEF = 4;
    localparam int N_IN_DEF    = 4;
    localparam int N_HID_DEF   = 4;
    localparam int N_OUT_DEF   = 2;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int NODE_W_DEF = $clog2(N_NODES_DEF);
    localparam int ROW_W_DEF  = $clog2(max2(N_IN_DEF, N_HID_DEF));
    localparam int COL_W_DEF  = $clog2(max2(N_HID_DEF, N_OUT_DEF));

    // One MAC cycle per term plus one write-back cycle per neuron.
    localparam int CYC_PER_NODE = N_HID_DEF * (N_IN_DEF + 1) + N_OUT_DEF * (N_HID_DEF + 1);
    localparam int TOTAL_CYC    = N_NODES_DEF * CYC_PER_NODE;

    function automatic int ready_idx(input int n, input int k, input int n_out);
        return n * n_out + k;
    endfunction

endpackage

// File: rtl/gnn_idx_counter.sv
// Nested row/col/layer/node index counter; term and column limits depend on the layer.
module gnn_idx_counter
    import gnn_sched_pkg::*;
#(
    parameter int N_NODES = N_NODES_DEF,
    parameter int N_IN    = N_IN_DEF,
    parameter int N_HID   = N_HID_DEF,
    parameter int N_OUT   = N_OUT_DEF,
    localparam int NODE_W = $clog2(N_NODES),
    localparam int ROW_W  = $clog2(max2(N_IN, N_HID)),
    localparam int COL_W  = $clog2(max2(N_HID, N_OUT))
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              step_row_i,
    input  logic              step_col_i,
    output logic [ROW_W-1:0]  row_o,
    output logic [COL_W-1:0]  col_o,
    output logic              layer_o,
    output logic [NODE_W-1:0] node_o,
    output logic              row_last_o,
    output logic              run_last_o
);

    logic [ROW_W-1:0]  row_q, row_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic              layer_q, layer_d;
    logic [NODE_W-1:0] node_q, node_d;

    logic [ROW_W-1:0]  row_lim;
    logic [COL_W-1:0]  col_lim;
    logic              col_last;
    logic              node_last;

    assign row_lim   = layer_q ? ROW_W'(N_HID - 1) : ROW_W'(N_IN - 1);
    assign col_lim   = layer_q ? COL_W'(N_OUT - 1) : COL_W'(N_HID - 1);
    assign col_last  = (col_q == col_lim);
    assign node_last = (node_q == NODE_W'(N_NODES - 1));

    // Row wraps on its own so the write-back cycle always presents row 0.
    always_comb begin
        row_d   = row_q;
        col_d   = col_q;
        layer_d = layer_q;
        node_d  = node_q;
        if (step_row_i) begin
            row_d = row_last_o ? '0 : row_q + 1'b1;
        end
        if (step_col_i) begin
            if (col_last) begin
                col_d = '0;
                if (layer_q) begin
                    layer_d = 1'b0;
                    node_d  = node_last ? '0 : node_q + 1'b1;
                end else begin
                    layer_d = 1'b1;
                end
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            row_q   <= '0;
            col_q   <= '0;
            layer_q <= 1'b0;
            node_q  <= '0;
        end else begin
            row_q   <= row_d;
            col_q   <= col_d;
            layer_q <= layer_d;
            node_q  <= node_d;
        end
    end

    assign row_o      = row_q;
    assign col_o      = col_q;
    assign layer_o    = layer_q;
    assign node_o     = node_q;
    assign row_last_o = (row_q == row_lim);
    assign run_last_o = col_last && layer_q && node_last;

endmodule

// File: rtl/gnn_mac_sched.sv
// Sequencer for a shared-MAC GNN datapath: FSM, strobe decode and sticky output-ready flags.
// Optional macro GNN_HIDDEN_RELU_EN drives hid_relu alongside hid_we.
module gnn_mac_sched
    import gnn_sched_pkg::*;
#(
    parameter int N_NODES = N_NODES_DEF,
    parameter int N_IN    = N_IN_DEF,
    parameter int N_HID   = N_HID_DEF,
    parameter int N_OUT   = N_OUT_DEF,
    localparam int NODE_W = $clog2(N_NODES),
    localparam int ROW_W  = $clog2(max2(N_IN, N_HID)),
    localparam int COL_W  = $clog2(max2(N_HID, N_OUT)),
    localparam int VEC_W  = N_NODES * N_OUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_ready,
    output logic              busy,
    output logic              sel_layer,
    output logic [NODE_W-1:0] sel_node,
    output logic [ROW_W-1:0]  sel_row,
    output logic [COL_W-1:0]  sel_col,
    output logic              mac_clr,
    output logic              mac_en,
    output logic              hid_we,
    output logic              hid_relu,
    output logic              out_we,
    output logic [VEC_W-1:0]  out_ready_vec,
    output logic              done
);

    state_e            state_q, state_d;
    logic              done_seen_q;
    logic [VEC_W-1:0]  vec_q, vec_d;
    logic [VEC_W-1:0]  set_mask;

    logic              cnt_clr, step_row, step_col;
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;
    logic              layer;
    logic [NODE_W-1:0] node;
    logic              row_last, run_last;

    gnn_idx_counter #(
        .N_NODES (N_NODES),
        .N_IN    (N_IN),
        .N_HID   (N_HID),
        .N_OUT   (N_OUT)
    ) u_idx (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (cnt_clr),
        .step_row_i (step_row),
        .step_col_i (step_col),
        .row_o      (row),
        .col_o      (col),
        .layer_o    (layer),
        .node_o     (node),
        .row_last_o (row_last),
        .run_last_o (run_last)
    );

    assign set_mask = VEC_W'(1) << ready_idx(int'(node), int'(col), N_OUT);

    // Dropping in_ready in MAC/WB aborts: the WB cycle that sees it does not mark a ready bit.
    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        cnt_clr  = 1'b0;
        step_row = 1'b0;
        step_col = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_ready) state_d = ST_MAC;
            end
            ST_MAC: begin
                if (!in_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    step_row = 1'b1;
                    if (row_last) state_d = ST_WB;
                end
            end
            ST_WB: begin
                if (!in_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    step_col = 1'b1;
                    if (layer) vec_d = vec_q | set_mask;
                    state_d = run_last ? ST_DONE : ST_MAC;
                end
            end
            ST_DONE: begin
                if (!in_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (state_d == ST_IDLE) begin
            cnt_clr = 1'b1;
            vec_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            done_seen_q <= 1'b0;
            vec_q       <= '0;
        end else begin
            state_q     <= state_d;
            done_seen_q <= (state_q == ST_DONE);
            vec_q       <= vec_d;
        end
    end

    // Every output is a decode of registered state; in_ready never reaches them combinationally.
    assign busy          = (state_q == ST_MAC) || (state_q == ST_WB);
    assign sel_layer     = layer;
    assign sel_node      = node;
    assign sel_row       = row;
    assign sel_col       = col;
    assign mac_en        = (state_q == ST_MAC);
    assign mac_clr       = (state_q == ST_MAC) && (row == '0);
    assign hid_we        = (state_q == ST_WB) && !layer;
    assign out_we        = (state_q == ST_WB) && layer;
    assign out_ready_vec = vec_q;
    assign done          = (state_q == ST_DONE) && !done_seen_q;

`ifdef GNN_HIDDEN_RELU_EN
    assign hid_relu = hid_we;
`else
    assign hid_relu = 1'b0;
`endif

endmodule

// File: tb/tb_gnn_mac_sched.sv
// Directed self-checking bench for gnn_mac_sched at default sizes (4 nodes, 4x4x2).
module tb_gnn_mac_sched;

`ifdef GNN_HIDDEN_RELU_EN
    localparam bit RELU_EN = 1'b1;
`else
    localparam bit RELU_EN = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       in_ready;
    logic       busy;
    logic       sel_layer;
    logic [1:0] sel_node;
    logic [1:0] sel_row;
    logic [1:0] sel_col;
    logic       mac_clr;
    logic       mac_en;
    logic       hid_we;
    logic       hid_relu;
    logic       out_we;
    logic [7:0] out_ready_vec;
    logic       done;

    int errors = 0;
    int checks = 0;

    gnn_mac_sched dut (
        .clk           (clk),
        .rst           (rst),
        .in_ready      (in_ready),
        .busy          (busy),
        .sel_layer     (sel_layer),
        .sel_node      (sel_node),
        .sel_row       (sel_row),
        .sel_col       (sel_col),
        .mac_clr       (mac_clr),
        .mac_en        (mac_en),
        .hid_we        (hid_we),
        .hid_relu      (hid_relu),
        .out_we        (out_we),
        .out_ready_vec (out_ready_vec),
        .done          (done)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [13:0] act_trace;
    assign act_trace = {busy, sel_layer, sel_node, sel_row, sel_col,
                        mac_clr, mac_en, hid_we, hid_relu, out_we, done};

    // Expected trace for busy cycle c (1..120): 30 cycles per node, 5 per neuron.
    function automatic logic [13:0] exp_trace(input int c);
        int idx, r, lay, col, t, node;
        logic mac, hid, outw;
        idx  = c - 1;
        node = idx / 30;
        r    = idx % 30;
        if (r < 20) begin
            lay = 0; col = r / 5; t = r % 5;
        end else begin
            lay = 1; col = (r - 20) / 5; t = (r - 20) % 5;
        end
        mac  = (t < 4);
        hid  = !mac && (lay == 0);
        outw = !mac && (lay == 1);
        return {1'b1, lay[0], node[1:0], (mac ? t[1:0] : 2'd0), col[1:0],
                (mac && (t == 0)), mac, hid, (RELU_EN && hid), outw, 1'b0};
    endfunction

    // Output k of node n is written at cycle n*30+25+5k and visible one cycle later.
    function automatic logic [7:0] exp_vec(input int c);
        logic [7:0] v;
        v = '0;
        for (int n = 0; n < 4; n++)
            for (int k = 0; k < 2; k++)
                if (c >= n * 30 + 26 + 5 * k) v[n * 2 + k] = 1'b1;
        return v;
    endfunction

    task automatic test_reset();
        rst      = 1'b1;
        in_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({act_trace, out_ready_vec} !== 22'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0", {act_trace, out_ready_vec});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (act_trace !== exp_trace(1)) begin
            errors++;
            $display("FAIL reset_first_mac got %h want %h", act_trace, exp_trace(1));
        end
        in_ready = 1'b0;
        @(negedge clk);
        checks++;
        if ({act_trace, out_ready_vec} !== 22'd0) begin
            errors++;
            $display("FAIL reset_abort_idle got %h want 0", {act_trace, out_ready_vec});
        end
    endtask

    task automatic test_full_run();
        int first_hid, first_out, last_out, done_cyc, vec0_cyc;
        int busy_cnt, n_hid, n_out, n_clr, n_en, n_multi;
        first_hid = -1; first_out = -1; last_out = -1; done_cyc = -1; vec0_cyc = -1;
        busy_cnt = 0; n_hid = 0; n_out = 0; n_clr = 0; n_en = 0; n_multi = 0;
        in_ready = 1'b1;
        for (int c = 1; c <= 121; c++) begin
            @(negedge clk);
            if (hid_we) begin n_hid++; if (first_hid < 0) first_hid = c; end
            if (out_we) begin n_out++; if (first_out < 0) first_out = c; last_out = c; end
            if (mac_clr) n_clr++;
            if (mac_en) n_en++;
            if (busy) busy_cnt++;
            if (done && done_cyc < 0) done_cyc = c;
            if (out_ready_vec[0] && vec0_cyc < 0) vec0_cyc = c;
            if (int'(mac_en) + int'(hid_we) + int'(out_we) + int'(done) > 1) n_multi++;
            if (c <= 120) begin
                checks++;
                if (act_trace !== exp_trace(c)) begin
                    errors++;
                    $display("FAIL run_trace c=%0d got %h want %h", c, act_trace, exp_trace(c));
                end
            end else begin
                checks++;
                if ({busy, mac_clr, mac_en, hid_we, hid_relu, out_we, done} !== 7'b0000001) begin
                    errors++;
                    $display("FAIL run_done_cycle got %b want 0000001",
                             {busy, mac_clr, mac_en, hid_we, hid_relu, out_we, done});
                end
            end
            checks++;
            if (out_ready_vec !== exp_vec(c)) begin
                errors++;
                $display("FAIL run_vec c=%0d got %h want %h", c, out_ready_vec, exp_vec(c));
            end
        end
        checks++; if (first_hid !== 5)   begin errors++; $display("FAIL first_hid_we got %0d want 5", first_hid); end
        checks++; if (first_out !== 25)  begin errors++; $display("FAIL first_out_we got %0d want 25", first_out); end
        checks++; if (vec0_cyc !== 26)   begin errors++; $display("FAIL vec_bit0_cycle got %0d want 26", vec0_cyc); end
        checks++; if (last_out !== 120)  begin errors++; $display("FAIL last_out_we got %0d want 120", last_out); end
        checks++; if (done_cyc !== 121)  begin errors++; $display("FAIL done_cycle got %0d want 121", done_cyc); end
        checks++; if (busy_cnt !== 120)  begin errors++; $display("FAIL busy_count got %0d want 120", busy_cnt); end
        checks++; if (n_hid !== 16)      begin errors++; $display("FAIL hid_we_count got %0d want 16", n_hid); end
        checks++; if (n_out !== 8)       begin errors++; $display("FAIL out_we_count got %0d want 8", n_out); end
        checks++; if (n_clr !== 24)      begin errors++; $display("FAIL mac_clr_count got %0d want 24", n_clr); end
        checks++; if (n_en !== 96)       begin errors++; $display("FAIL mac_en_count got %0d want 96", n_en); end
        checks++; if (n_multi !== 0)     begin errors++; $display("FAIL strobe_overlap got %0d want 0", n_multi); end
    endtask

    task automatic test_done_hold();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if ({out_ready_vec, busy, mac_en, hid_we, out_we, done} !== {8'hFF, 5'b0}) begin
                errors++;
                $display("FAIL done_hold i=%0d got %h want %h", i,
                         {out_ready_vec, busy, mac_en, hid_we, out_we, done}, {8'hFF, 5'b0});
            end
        end
        in_ready = 1'b0;
        @(negedge clk);
        checks++;
        if ({out_ready_vec, busy, done} !== 10'd0) begin
            errors++;
            $display("FAIL done_release got %h want 0", {out_ready_vec, busy, done});
        end
    endtask

    task automatic test_abort();
        in_ready = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            checks++;
            if ({act_trace, out_ready_vec} !== {exp_trace(c), exp_vec(c)}) begin
                errors++;
                $display("FAIL abort_prefix c=%0d got %h want %h", c,
                         {act_trace, out_ready_vec}, {exp_trace(c), exp_vec(c)});
            end
        end
        in_ready = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            checks++;
            if ({act_trace, out_ready_vec} !== 22'd0) begin
                errors++;
                $display("FAIL abort_idle i=%0d got %h want 0", i, {act_trace, out_ready_vec});
            end
        end
        in_ready = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            checks++;
            if (act_trace !== exp_trace(c)) begin
                errors++;
                $display("FAIL abort_restart c=%0d got %h want %h", c, act_trace, exp_trace(c));
            end
        end
        in_ready = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        in_ready = 1'b1;
        repeat (30) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({act_trace, out_ready_vec} !== 22'd0) begin
            errors++;
            $display("FAIL midrun_reset got %h want 0", {act_trace, out_ready_vec});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (act_trace !== exp_trace(1)) begin
            errors++;
            $display("FAIL midrun_restart got %h want %h", act_trace, exp_trace(1));
        end
        in_ready = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst      = 1'b1;
        in_ready = 1'b0;
        test_reset();
        test_full_run();
        test_done_hold();
        test_abort();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
